// File: rtl/aes_job_pkg.sv
// rtl/aes_job_pkg.sv - shared state type, default widths and status bit positions for the AES job sequencer
package aes_job_pkg;

    localparam int AES_CNT_W = 16;
    localparam int AES_KEY_W = 128;

    // Status bit positions shared with the register bank
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } job_state_t;

endpackage

// File: rtl/aes_job_wdog.sv
// rtl/aes_job_wdog.sv - loadable down-counter that flags expiry after CYCLES enabled cycles without a reload
module aes_job_wdog
    import aes_job_pkg::*;
#(
    parameter int CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down while enabled and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A reload in the expiry cycle wins, so a late handshake still rescues the job
    assign expired = en && !load && (cnt == '0);

endmodule

// File: rtl/aes_job_ctrl.sv
// rtl/aes_job_ctrl.sv - AES-128 job sequencer: key load, gated block stream, result count, irq; watchdog under AES_JOB_WDOG_EN
module aes_job_ctrl
    import aes_job_pkg::*;
#(
    parameter int CNT_W       = AES_CNT_W,
    parameter int KEY_W       = AES_KEY_W,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [CNT_W-1:0] cfg_nblocks,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_err,
    output logic [CNT_W-1:0] stat_blocks_out,
    output logic             irq,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_data,
    input  logic             key_ready,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic             core_tvalid,
    input  logic             core_tready,
    input  logic             out_tvalid,
    input  logic             out_tready
);

    job_state_t       state;
    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] nblocks_q;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] in_cnt_nxt;
    logic [CNT_W-1:0] out_cnt_nxt;
    logic             gate;
    logic             in_hs;
    logic             out_hs;
    logic             wdog_expired;

    // The gate is a pure decode of the state register; only valid/ready pass through combinationally
    assign gate        = (state == RUN);
    assign core_tvalid = gate & in_tvalid;
    assign in_tready   = gate & core_tready;
    assign in_hs       = gate & in_tvalid & core_tready;

    // Result beats count only while a job is streaming and stop at the job length
    assign out_hs      = out_tvalid & out_tready & ((state == RUN) || (state == DRAIN))
                         & (out_cnt != nblocks_q);
    assign in_cnt_nxt  = in_cnt + CNT_W'(1);
    assign out_cnt_nxt = out_hs ? (out_cnt + CNT_W'(1)) : out_cnt;

    assign stat_busy       = (state == KEY) || (state == RUN) || (state == DRAIN);
    assign key_valid       = (state == KEY);
    assign key_data        = key_q;
    assign stat_blocks_out = out_cnt;

`ifdef AES_JOB_WDOG_EN
    logic wdog_en;
    logic wdog_load;

    // Outside KEY/DRAIN the counter sits preloaded, so every entry starts a full timeout
    assign wdog_en   = (state == KEY) || (state == DRAIN);
    assign wdog_load = !wdog_en || (key_valid & key_ready) || out_hs;

    aes_job_wdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .load    (wdog_load),
        .en      (wdog_en),
        .expired (wdog_expired)
    );
`else
    logic [31:0] wdog_cycles_unused;
    assign wdog_cycles_unused = WDOG_CYCLES;
    assign wdog_expired       = 1'b0;
`endif

    // Job FSM with counters, sticky status and the one-cycle irq
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            key_q     <= '0;
            nblocks_q <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            stat_done <= 1'b0;
            stat_err  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (in_hs) begin
                in_cnt <= in_cnt_nxt;
            end
            if (out_hs) begin
                out_cnt <= out_cnt_nxt;
            end
            case (state)
                IDLE: begin
                    // A start in IDLE always wins over a simultaneous abort
                    if (cfg_start) begin
                        key_q     <= cfg_key;
                        nblocks_q <= cfg_nblocks;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        stat_err  <= 1'b0;
                        if (cfg_nblocks == '0) begin
                            state     <= DONE;
                            stat_done <= 1'b1;
                            irq       <= 1'b1;
                        end else begin
                            state     <= KEY;
                            stat_done <= 1'b0;
                        end
                    end
                end
                KEY, RUN, DRAIN: begin
                    if (cfg_abort || wdog_expired) begin
                        state    <= IDLE;
                        stat_err <= 1'b1;
                        irq      <= 1'b1;
                    end else begin
                        if (cfg_start) begin
                            stat_err <= 1'b1;
                        end
                        if ((state == KEY) && key_ready) begin
                            state <= RUN;
                        end
                        if ((state == RUN) && in_hs && (in_cnt_nxt == nblocks_q)) begin
                            state <= DRAIN;
                        end
                        if ((state == DRAIN) && (out_cnt_nxt == nblocks_q)) begin
                            state     <= DONE;
                            stat_done <= 1'b1;
                            irq       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_job_ctrl.sv
// tb/tb_aes_job_ctrl.sv - randomized self-checking bench for aes_job_ctrl against a job-level reference model
module tb_aes_job_ctrl;

    localparam int CNT_W = 16;
    localparam int KEY_W = 128;
    localparam int WD    = 16;
    localparam int VW    = 7 + CNT_W + KEY_W;

    logic             ACLK = 1'b0;
    logic             ARESETN;
    logic             cfg_start, cfg_abort;
    logic [KEY_W-1:0] cfg_key;
    logic [CNT_W-1:0] cfg_nblocks;
    logic             stat_busy, stat_done, stat_err, irq;
    logic [CNT_W-1:0] stat_blocks_out;
    logic             key_valid, key_ready;
    logic [KEY_W-1:0] key_data;
    logic             in_tvalid, in_tready, core_tvalid, core_tready;
    logic             out_tvalid, out_tready;

    aes_job_ctrl #(
        .CNT_W       (CNT_W),
        .KEY_W       (KEY_W),
        .WDOG_CYCLES (WD)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_key         (cfg_key),
        .cfg_nblocks     (cfg_nblocks),
        .stat_busy       (stat_busy),
        .stat_done       (stat_done),
        .stat_err        (stat_err),
        .stat_blocks_out (stat_blocks_out),
        .irq             (irq),
        .key_valid       (key_valid),
        .key_data        (key_data),
        .key_ready       (key_ready),
        .in_tvalid       (in_tvalid),
        .in_tready       (in_tready),
        .core_tvalid     (core_tvalid),
        .core_tready     (core_tready),
        .out_tvalid      (out_tvalid),
        .out_tready      (out_tready)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Job-level reference: a job is active, waiting for its key or not, with counts of blocks in and out
    bit               m_active, m_keyp, m_donecyc, m_done, m_err, m_irq;
    int               m_in, m_out, m_n, m_wait;
    logic [KEY_W-1:0] m_key;

    task automatic model_reset();
        m_active = 0; m_keyp = 0; m_donecyc = 0; m_done = 0; m_err = 0; m_irq = 0;
        m_in = 0; m_out = 0; m_n = 0; m_wait = 0; m_key = '0;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        bit gate;
        gate = m_active && !m_keyp && (m_in < m_n);
        return {m_active, m_done, m_err, m_irq, m_active && m_keyp, gate && core_tready,
                gate && in_tvalid, CNT_W'(m_out), m_key};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {stat_busy, stat_done, stat_err, irq, key_valid, in_tready, core_tvalid,
                stat_blocks_out, key_data};
    endfunction

    // Advance the reference by one clock edge using the inputs currently applied
    task automatic model_edge();
        bit gate, hs_in, hs_out, drain, wd_fire, irq_n;
        irq_n = 0;
        wd_fire = 0;
        gate = m_active && !m_keyp && (m_in < m_n);
        if (m_donecyc) begin
            m_donecyc = 0;
        end else if (!m_active) begin
            if (cfg_start) begin
                m_key = cfg_key; m_n = int'(cfg_nblocks); m_in = 0; m_out = 0; m_err = 0; m_wait = 0;
                if (cfg_nblocks == 0) begin
                    m_done = 1; irq_n = 1; m_donecyc = 1;
                end else begin
                    m_done = 0; m_active = 1; m_keyp = 1;
                end
            end
        end else begin
            hs_in  = gate && in_tvalid && core_tready;
            hs_out = !m_keyp && out_tvalid && out_tready && (m_out < m_n);
            drain  = !m_keyp && (m_in == m_n);
`ifdef AES_JOB_WDOG_EN
            if ((m_keyp && !key_ready) || (drain && !hs_out)) begin
                if (m_wait == WD - 1) wd_fire = 1;
                else m_wait++;
            end else begin
                m_wait = 0;
            end
`endif
            if (hs_in) m_in++;
            if (hs_out) m_out++;
            if (cfg_abort || wd_fire) begin
                m_active = 0; m_keyp = 0; m_err = 1; irq_n = 1;
            end else begin
                if (cfg_start) m_err = 1;
                if (m_keyp) begin
                    if (key_ready) m_keyp = 0;
                end else if (drain && (m_out == m_n)) begin
                    m_active = 0; m_done = 1; irq_n = 1; m_donecyc = 1;
                end
            end
        end
        m_irq = irq_n;
    endtask

    task automatic idle_inputs();
        cfg_start = 0; cfg_abort = 0; cfg_key = '0; cfg_nblocks = '0;
        key_ready = 0; in_tvalid = 0; core_tready = 0; out_tvalid = 0; out_tready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESETN = 0;
        model_reset();
        #2;
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", dut_vec());
        end
        @(negedge ACLK);
        ARESETN = 1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
        end
        model_edge();
        @(posedge ACLK); #1;
    endtask

    task automatic test_nominal();
        int kv = 0;
        bit fin = 0;
        logic [KEY_W-1:0] k;
        for (int i = 0; i < 16; i++) k[127 - 8*i -: 8] = 8'(i);
        idle_inputs();
        cfg_key = k; cfg_nblocks = 4; cfg_start = 1;
        key_ready = 1; core_tready = 1; out_tready = 1; in_tvalid = 1;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c > 0) cfg_start = 0;
            out_tvalid = (m_in > m_out);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL nominal cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (key_valid) kv++;
            fin = m_donecyc;
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (!fin || kv !== 1 || stat_blocks_out !== 16'd4 || stat_done !== 1'b1) begin
            n_fail++; $display("FAIL nominal_end: fin=%0d key_valid_cycles=%0d blocks=%0d done=%b want 1/1/4/1",
                               fin, kv, stat_blocks_out, stat_done);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        bit fin = 0;
        idle_inputs();
        cfg_key = {4{32'hA5A5_0001}}; cfg_nblocks = 3; cfg_start = 1;
        key_ready = 1; in_tvalid = 1;
        for (int c = 0; c < 60 && !fin; c++) begin
            if (c > 0) cfg_start = 0;
            core_tready = c[0];
            out_tvalid = (m_in > m_out);
            out_tready = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL backpressure cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (core_tvalid && core_tready) beats++;
            fin = m_donecyc;
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (!fin || beats !== 3 || stat_blocks_out !== 16'd3) begin
            n_fail++; $display("FAIL backpressure_end: fin=%0d core_beats=%0d blocks=%0d want 1/3/3",
                               fin, beats, stat_blocks_out);
        end
    endtask

    task automatic test_zero_len();
        int kv = 0;
        int irq_cyc = -1;
        idle_inputs();
        cfg_key = {4{32'h0BAD_F00D}}; cfg_nblocks = 0; cfg_start = 1;
        key_ready = 1; in_tvalid = 1; core_tready = 1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cfg_start = 0;
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL zero_len cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (key_valid) kv++;
            if (irq && irq_cyc < 0) irq_cyc = c;
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (kv !== 0 || irq_cyc !== 1 || stat_blocks_out !== 16'd0 || stat_done !== 1'b1) begin
            n_fail++; $display("FAIL zero_len_end: key_valid_cycles=%0d irq_cycle=%0d blocks=%0d done=%b want 0/1/0/1",
                               kv, irq_cyc, stat_blocks_out, stat_done);
        end
    endtask

    task automatic test_abort();
        bit aborted = 0;
        bit fin = 0;
        int post = 0;
        idle_inputs();
        cfg_key = {4{32'h1234_5678}}; cfg_nblocks = 8; cfg_start = 1;
        key_ready = 1; core_tready = 1; in_tvalid = 1; out_tready = 1;
        for (int c = 0; c < 40 && post < 4; c++) begin
            cfg_start = (c == 0);
            cfg_abort = 0;
            in_tvalid = 1;
            if (m_in >= 2 && !aborted) begin
                in_tvalid = 0; cfg_abort = 1; aborted = 1;
            end else if (aborted) begin
                post++;
            end
            out_tvalid = (m_in > m_out);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL abort cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (stat_err !== 1'b1 || stat_busy !== 1'b0 || in_tready !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: err=%b busy=%b in_tready=%b want 1/0/0", stat_err, stat_busy, in_tready);
        end
        cfg_nblocks = 1; cfg_key = {4{32'hCAFE_0002}};
        for (int c = 0; c < 30 && !fin; c++) begin
            cfg_start = (c == 0);
            out_tvalid = (m_in > m_out);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL abort_restart cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            fin = m_donecyc;
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (!fin || stat_err !== 1'b0 || stat_done !== 1'b1 || stat_blocks_out !== 16'd1) begin
            n_fail++; $display("FAIL abort_restart_end: fin=%0d err=%b done=%b blocks=%0d want 1/0/1/1",
                               fin, stat_err, stat_done, stat_blocks_out);
        end
    endtask

    task automatic test_start_busy();
        bit second = 0;
        bit fin = 0;
        idle_inputs();
        cfg_key = {4{32'h5555_AAAA}}; cfg_nblocks = 5; cfg_start = 1;
        key_ready = 1; core_tready = 1; in_tvalid = 1; out_tready = 1;
        for (int c = 0; c < 60 && !fin; c++) begin
            cfg_start = (c == 0);
            if (m_in == 2 && !second) begin
                cfg_start = 1; cfg_nblocks = 9; cfg_key = '1; second = 1;
            end
            out_tvalid = (m_in > m_out);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL start_busy cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            fin = m_donecyc;
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (!fin || stat_err !== 1'b1 || stat_done !== 1'b1 || stat_blocks_out !== 16'd5) begin
            n_fail++; $display("FAIL start_busy_end: fin=%0d err=%b done=%b blocks=%0d want 1/1/1/5",
                               fin, stat_err, stat_done, stat_blocks_out);
        end
    endtask

    task automatic test_key_stall();
        int kv = 0;
        int kv_exp;
        idle_inputs();
        cfg_key = {4{32'hDEAD_BEEF}}; cfg_nblocks = 2;
        for (int c = 0; c <= 100; c++) begin
            cfg_start = (c == 0);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL key_stall cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (key_valid) kv++;
            model_edge();
            @(posedge ACLK); #1;
        end
`ifdef AES_JOB_WDOG_EN
        kv_exp = WD;
`else
        kv_exp = 100;
`endif
        n_checks++;
        if (kv !== kv_exp) begin
            n_fail++; $display("FAIL key_stall_len: key_valid_cycles=%0d want %0d", kv, kv_exp);
        end
        for (int c = 0; c < 3; c++) begin
            cfg_abort = (c == 0);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL key_stall_abort cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            model_edge();
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (stat_err !== 1'b1 || stat_busy !== 1'b0) begin
            n_fail++; $display("FAIL key_stall_end: err=%b busy=%b want 1/0", stat_err, stat_busy);
        end
    endtask

    task automatic test_random();
        bit fin;
        int gap;
        for (int j = 0; j < 12; j++) begin
            idle_inputs();
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                cfg_abort = 1'($urandom_range(0, 1));
                in_tvalid = 1'($urandom_range(0, 1));
                core_tready = 1'($urandom_range(0, 1));
                @(negedge ACLK);
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL random_idle job %0d: got %h want %h", j, dut_vec(), exp_vec());
                end
                model_edge();
                @(posedge ACLK); #1;
            end
            cfg_abort = 0;
            fin = 0;
            for (int c = 0; c < 300 && !fin; c++) begin
                if (c == 0) begin
                    cfg_start = 1;
                    cfg_key = {$urandom(), $urandom(), $urandom(), $urandom()};
                    cfg_nblocks = CNT_W'($urandom_range(1, 6));
                end else begin
                    cfg_start = ($urandom_range(0, 15) == 0);
                    cfg_nblocks = CNT_W'($urandom_range(0, 20));
                    cfg_abort = ($urandom_range(0, 63) == 0);
                end
                key_ready   = 1'($urandom_range(0, 1));
                in_tvalid   = 1'($urandom_range(0, 1));
                core_tready = 1'($urandom_range(0, 1));
                out_tvalid  = 1'($urandom_range(0, 1));
                out_tready  = ($urandom_range(0, 3) != 0);
                @(negedge ACLK);
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL random job %0d cyc %0d: got %h want %h", j, c, dut_vec(), exp_vec());
                end
                model_edge();
                fin = !m_active && !m_donecyc;
                @(posedge ACLK); #1;
            end
            n_checks++;
            if (!fin) begin
                n_fail++; $display("FAIL random_timeout job %0d: busy=%b want job finished", j, stat_busy);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        idle_inputs();
        cfg_key = {4{32'h7777_1111}}; cfg_nblocks = 3; key_ready = 1; core_tready = 1; in_tvalid = 1;
        for (int c = 0; c < 4; c++) begin
            cfg_start = (c == 0);
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid pre cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            model_edge();
            @(posedge ACLK); #1;
        end
        #1 ARESETN = 0;
        #1;
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL reset_mid_async: got %h want 0", dut_vec());
        end
        model_reset();
        idle_inputs();
        @(negedge ACLK);
        ARESETN = 1;
        @(posedge ACLK); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid post cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            model_edge();
            @(posedge ACLK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_start_busy();
        test_key_stall();
        test_random();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
